// File: rtl/led_frame_tx.sv
// Three-wire (clock/data/latch) serial transmitter for 74HC595-style LED chains.
// Holds one pending word; words overwritten before transmission are counted.
module led_frame_tx #(
  parameter int unsigned DATA_W  = 10,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ser_clk,
  output logic              o_ser_dat,
  output logic              o_ser_latch,
  output logic              o_busy,
  output logic [7:0]        o_drop_cnt
);

  localparam int unsigned BW = $clog2(DATA_W) + 1;
  localparam int unsigned PW = $clog2(CLK_DIV) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t            r_state, w_state;
  logic [DATA_W-1:0] r_sh, w_sh;
  logic [BW-1:0]     r_bit, w_bit;
  logic [PW-1:0]     r_ph, w_ph;
  logic [DATA_W-1:0] r_pend, w_pend;
  logic              r_pend_v, w_pend_v;
  logic [7:0]        r_drop_cnt, w_drop_cnt;
  logic              r_ser_clk, r_ser_dat, r_ser_latch, r_busy;
  logic              w_ser_clk, w_ser_dat, w_ser_latch, w_busy;
  logic              w_ph_done, w_last_bit, w_latch_exit;

  assign w_ph_done    = (r_ph == PW'(CLK_DIV - 1));
  assign w_last_bit   = (r_bit == BW'(DATA_W - 1));
  assign w_latch_exit = (r_state == LATCH) && w_ph_done;

  // Next-state, datapath and next-output logic; outputs follow the next state.
  always_comb begin
    w_state    = r_state;
    w_sh       = r_sh;
    w_bit      = r_bit;
    w_ph       = r_ph;
    w_pend     = r_pend;
    w_pend_v   = r_pend_v;
    w_drop_cnt = r_drop_cnt;

    case (r_state)
      IDLE: begin
        if (i_valid) begin
          w_sh    = i_data;
          w_bit   = '0;
          w_ph    = '0;
          w_state = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (w_ph_done) begin
          w_ph    = '0;
          w_state = SHIFT_HI;
        end else begin
          w_ph = r_ph + PW'(1);
        end
      end
      SHIFT_HI: begin
        if (w_ph_done) begin
          w_ph    = '0;
          w_sh    = r_sh << 1;
          w_bit   = r_bit + BW'(1);
          w_state = w_last_bit ? LATCH : SHIFT_LO;
        end else begin
          w_ph = r_ph + PW'(1);
        end
      end
      LATCH: begin
        if (w_ph_done) begin
          w_ph  = '0;
          w_bit = '0;
          if (r_pend_v) begin
            w_sh     = r_pend;
            w_pend_v = 1'b0;
            w_state  = SHIFT_LO;
          end else if (i_valid) begin
            w_sh    = i_data;
            w_state = SHIFT_LO;
          end else begin
            w_state = IDLE;
          end
        end else begin
          w_ph = r_ph + PW'(1);
        end
      end
      default: w_state = IDLE;
    endcase

    // A strobe outside IDLE lands in pend unless it went straight into sh at latch exit.
    if (i_valid && (r_state != IDLE) && !(w_latch_exit && !r_pend_v)) begin
      w_pend   = i_data;
      w_pend_v = 1'b1;
      if (r_pend_v && !w_latch_exit && (r_drop_cnt != 8'hFF))
        w_drop_cnt = r_drop_cnt + 8'd1;
    end

    w_ser_clk   = (w_state == SHIFT_HI);
    w_ser_dat   = ((w_state == SHIFT_LO) || (w_state == SHIFT_HI)) && w_sh[DATA_W-1];
    w_ser_latch = (w_state == LATCH);
    w_busy      = (w_state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sh        <= '0;
      r_bit       <= '0;
      r_ph        <= '0;
      r_pend      <= '0;
      r_pend_v    <= 1'b0;
      r_drop_cnt  <= 8'd0;
      r_ser_clk   <= 1'b0;
      r_ser_dat   <= 1'b0;
      r_ser_latch <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sh        <= w_sh;
      r_bit       <= w_bit;
      r_ph        <= w_ph;
      r_pend      <= w_pend;
      r_pend_v    <= w_pend_v;
      r_drop_cnt  <= w_drop_cnt;
      r_ser_clk   <= w_ser_clk;
      r_ser_dat   <= w_ser_dat;
      r_ser_latch <= w_ser_latch;
      r_busy      <= w_busy;
    end
  end

  assign o_ser_clk   = r_ser_clk;
  assign o_ser_dat   = r_ser_dat;
  assign o_ser_latch = r_ser_latch;
  assign o_busy      = r_busy;
  assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_led_frame_tx.sv
// Self-checking bench for led_frame_tx: decodes the serial link into frames and
// compares them against a queue of words expected to go out.
module tb_led_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [9:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic       o_ser_clk, o_ser_dat, o_ser_latch, o_busy;
  logic [7:0] o_drop_cnt;

  logic [0:0] t_data = '0;
  logic       t_valid = 1'b0;
  logic       t_ser_clk, t_ser_dat, t_ser_latch, t_busy;
  logic [7:0] t_drop_cnt;

  logic [9:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ser_clk, s_ser_dat, s_ser_latch, s_busy;
  logic [7:0] s_drop_cnt;

  always #20 clk = ~clk;

  led_frame_tx #(.DATA_W(10), .CLK_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .o_ser_clk(o_ser_clk), .o_ser_dat(o_ser_dat), .o_ser_latch(o_ser_latch),
    .o_busy(o_busy), .o_drop_cnt(o_drop_cnt));

  led_frame_tx #(.DATA_W(1), .CLK_DIV(1)) u_tiny (
    .clk(clk), .rst(rst), .i_data(t_data), .i_valid(t_valid),
    .o_ser_clk(t_ser_clk), .o_ser_dat(t_ser_dat), .o_ser_latch(t_ser_latch),
    .o_busy(t_busy), .o_drop_cnt(t_drop_cnt));

  led_frame_tx #(.DATA_W(10), .CLK_DIV(32)) u_slow (
    .clk(clk), .rst(rst), .i_data(s_data), .i_valid(s_valid),
    .o_ser_clk(s_ser_clk), .o_ser_dat(s_ser_dat), .o_ser_latch(s_ser_latch),
    .o_busy(s_busy), .o_drop_cnt(s_drop_cnt));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [9:0] sb_q[$];

  // Link monitor: rebuilds frames from rising serial-clock edges.
  logic       prev_clk = 1'b0, prev_dat = 1'b0, prev_latch = 1'b0;
  logic [9:0] cap = '0;
  int         bits = 0, latch_len = 0, busy_cyc = 0, frames = 0, timing_err = 0;

  always @(negedge clk) begin
    if (rst) begin
      cap = '0; bits = 0; latch_len = 0;
    end else begin
      if (o_ser_clk && o_ser_dat != prev_dat) timing_err++;
      if (o_ser_clk && !prev_clk) begin
        cap = {cap[8:0], o_ser_dat};
        bits++;
      end
      if (o_busy) busy_cyc++;
      if (o_ser_latch) latch_len++;
      if (o_ser_latch && !prev_latch) begin
        if (sb_q.size() == 0) check("sb_empty_on_frame", 32'(cap), 32'hFFFF_FFFF);
        else check("frame_data", 32'(cap), 32'(sb_q.pop_front()));
        check("frame_bits", 32'(bits), 32'd10);
        check("data_timing", 32'(timing_err), 32'd0);
        cap = '0; bits = 0; frames++;
      end
      if (!o_ser_latch && prev_latch) begin
        check("latch_width", 32'(latch_len), 32'd4);
        latch_len = 0;
      end
    end
    prev_clk   = o_ser_clk;
    prev_dat   = o_ser_dat;
    prev_latch = o_ser_latch;
  end

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic strobe(input logic [9:0] d);
    i_data  = d;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (!o_busy) break;
      @(negedge clk);
    end
    check("idle_timeout", 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [3:0] tiny_exp [4];
    int f0;

    // Reset state
    apply_reset();
    check("reset_outputs", 32'({o_busy, o_ser_latch, o_ser_clk, o_ser_dat}), 32'd0);
    check("reset_drop", 32'(o_drop_cnt), 32'd0);

    // Single frame: MSB first, 84 busy cycles
    busy_cyc = 0;
    sb_q.push_back(10'b10_1100_0011);
    strobe(10'b10_1100_0011);
    check("latency_busy", 32'(o_busy), 32'd1);
    check("latency_first_bit", 32'(o_ser_dat), 32'd1);
    wait_idle(200);
    check("single_busy_cycles", 32'(busy_cyc), 32'd84);
    check("single_drop", 32'(o_drop_cnt), 32'd0);
    check("single_frames", 32'(frames), 32'd1);

    // Back-to-back: pending word follows with no idle gap
    busy_cyc = 0;
    sb_q.push_back(10'h3A5);
    strobe(10'h3A5);
    repeat (20) @(negedge clk);
    sb_q.push_back(10'h155);
    strobe(10'h155);
    wait_idle(400);
    check("b2b_busy_cycles", 32'(busy_cyc), 32'd168);
    check("b2b_frames", 32'(frames), 32'd3);

    // Overwrites: only the last pending word is sent
    apply_reset();
    sb_q.push_back(10'h0AA);
    strobe(10'h0AA);
    repeat (10) @(negedge clk);
    strobe(10'h001);
    strobe(10'h002);
    sb_q.push_back(10'h003);
    strobe(10'h003);
    wait_idle(400);
    check("overwrite_drop", 32'(o_drop_cnt), 32'd2);
    check("overwrite_frames", 32'(frames), 32'd5);

    // Saturation on a slow instance: 301 consecutive strobes in one frame
    s_data  = 10'h2F0;
    s_valid = 1'b1;
    repeat (201) @(negedge clk);
    s_valid = 1'b0;
    check("slow_drop_199", 32'(s_drop_cnt), 32'd199);
    check("slow_busy", 32'(s_busy), 32'd1);
    s_valid = 1'b1;
    repeat (100) @(negedge clk);
    s_valid = 1'b0;
    check("slow_drop_sat", 32'(s_drop_cnt), 32'd255);

    // Mid-frame reset with a pending word
    apply_reset();
    f0 = frames;
    strobe(10'h3FF);
    repeat (19) @(negedge clk);
    strobe(10'h155);
    repeat (19) @(negedge clk);
    check("pre_reset_busy", 32'(o_busy), 32'd1);
    #5 rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'({o_busy, o_ser_latch, o_ser_clk, o_ser_dat}), 32'd0);
    check("async_reset_drop", 32'(o_drop_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    busy_cyc = 0;
    repeat (200) @(negedge clk);
    check("post_reset_quiet", 32'(busy_cyc), 32'd0);
    check("post_reset_frames", 32'(frames), 32'(f0));

    // Minimal configuration: DATA_W=1, CLK_DIV=1; vector is {busy,latch,clk,dat}
    tiny_exp[0] = 4'b1001;
    tiny_exp[1] = 4'b1011;
    tiny_exp[2] = 4'b1100;
    tiny_exp[3] = 4'b0000;
    t_data  = 1'b1;
    t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("tiny_cycle%0d", k + 1),
            32'({t_busy, t_ser_latch, t_ser_clk, t_ser_dat}), 32'(tiny_exp[k]));
      @(negedge clk);
    end

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
